// File: rtl/calc_chain_accum.sv
// calc_chain_accum: keypad calculator engine. It builds decimal operands and chains ADD/SUB/MUL
// left to right, with a sticky overflow flag. Define CALC_DIV_EN to enable op 6 = DIV (restoring divider).
module calc_chain_accum #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            digit_valid,
    input  logic [3:0]                      digit,
    input  logic                            op_valid,
    input  logic [2:0]                      op,
    output logic [WIDTH-1:0]                value,
    output logic                            result_valid,
    output logic                            busy,
    output logic                            ovf,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int NW = $clog2(WIDTH);
    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIM = POS_LIM + (2*WIDTH)'(1);

    function automatic bit digits_fit();
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < MAX_DIGITS; i++) p = p * 128'd10;
        return (p - 128'd1) < (128'd1 << (WIDTH - 1));
    endfunction

    if (!digits_fit()) begin : g_param_check
        $error("calc_chain_accum: 10**MAX_DIGITS-1 does not fit in a signed WIDTH-bit value");
    end

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_NEG = 3'd3,
        OP_EQU = 3'd4, OP_CLR = 3'd5, OP_DIV = 3'd6, OP_RSV = 3'd7
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_EXEC, S_DONE} state_e;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    state_e             state, state_nxt;
    op_e                key_op, pending_op, exec_op;
    logic [WIDTH-1:0]   acc, operand, rhs, entry_val, exec_res;
    logic               neg, after_equ, res_neg, exec_ovf, exec_last;
    logic [NW-1:0]      cnt;
    logic [2*WIDTH-1:0] mul_a, prod, prod_nxt;
    logic [WIDTH-1:0]   mul_b;
    logic [WIDTH:0]     sum;
    logic               is_commit, accept, idle_like, has_operand, digit_room;
    logic               do_clr, do_commit, do_exec, do_neg, do_digit;
`ifdef CALC_DIV_EN
    logic [WIDTH-1:0]   div_dvd, div_dvs, div_rem, div_quo, div_rem_nxt, div_quo_nxt;
    logic [WIDTH:0]     div_trial, div_diff;
`endif

    assign key_op      = op_e'(op);
    assign accept      = (state != S_EXEC);
    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign has_operand = (digit_cnt != '0);
    assign digit_room  = (digit_cnt != CW'(MAX_DIGITS));
    assign do_clr      = op_valid && (key_op == OP_CLR);
    assign do_commit   = op_valid && accept && is_commit;
    assign do_exec     = do_commit && has_operand;
    assign do_neg      = op_valid && accept && (key_op == OP_NEG);
    assign do_digit    = digit_valid && !op_valid && accept && (digit <= 4'd9);
    assign entry_val   = neg ? -operand : operand;
    assign value       = ((state == S_ENTRY) || neg) ? entry_val : acc;
    assign prod_nxt    = prod + (mul_b[0] ? mul_a : '0);
    assign exec_last   = (exec_op == OP_ADD) || (exec_op == OP_SUB) || (cnt == NW'(WIDTH - 1));

    always_comb begin
        is_commit = 1'b0;
        case (key_op)
            OP_ADD, OP_SUB, OP_MUL, OP_EQU: is_commit = 1'b1;
`ifdef CALC_DIV_EN
            OP_DIV:                         is_commit = 1'b1;
`endif
            default:                        is_commit = 1'b0;
        endcase
    end

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        busy         = (state == S_EXEC);
        result_valid = (state == S_DONE);
        if (do_clr) state_nxt = S_IDLE;
        else begin
            case (state)
                S_IDLE, S_DONE: state_nxt = do_digit ? S_ENTRY : S_IDLE;
                S_ENTRY:        if (do_exec) state_nxt = S_EXEC;
                S_EXEC:         if (exec_last) state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

`ifdef CALC_DIV_EN
    // One restoring step: shift in the next dividend bit, subtract when no borrow.
    always_comb begin
        div_trial   = {div_rem, div_dvd[WIDTH-1]};
        div_diff    = div_trial - {1'b0, div_dvs};
        div_rem_nxt = div_trial[WIDTH-1:0];
        div_quo_nxt = {div_quo[WIDTH-2:0], 1'b0};
        if (!div_diff[WIDTH]) begin
            div_rem_nxt    = div_diff[WIDTH-1:0];
            div_quo_nxt[0] = 1'b1;
        end
    end
`endif

    always_comb begin
        exec_res = acc;
        exec_ovf = 1'b0;
        sum      = '0;
        case (exec_op)
            OP_ADD, OP_SUB: begin
                sum = (exec_op == OP_ADD) ? {acc[WIDTH-1], acc} + {rhs[WIDTH-1], rhs}
                                          : {acc[WIDTH-1], acc} - {rhs[WIDTH-1], rhs};
                exec_res = sum[WIDTH-1:0];
                exec_ovf = sum[WIDTH] ^ sum[WIDTH-1];
            end
            OP_MUL: begin
                exec_res = res_neg ? -prod_nxt[WIDTH-1:0] : prod_nxt[WIDTH-1:0];
                exec_ovf = prod_nxt > (res_neg ? NEG_LIM : POS_LIM);
            end
`ifdef CALC_DIV_EN
            OP_DIV: begin
                if (div_dvs == '0) exec_ovf = 1'b1;
                else begin
                    exec_res = res_neg ? -div_quo_nxt : div_quo_nxt;
                    exec_ovf = !res_neg && div_quo_nxt[WIDTH-1];
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0; operand <= '0; neg <= 1'b0; after_equ <= 1'b0;
            pending_op <= OP_ADD; digit_cnt <= '0; ovf <= 1'b0;
        end else if (do_clr) begin
            acc <= '0; operand <= '0; neg <= 1'b0; after_equ <= 1'b0;
            pending_op <= OP_ADD; digit_cnt <= '0; ovf <= 1'b0;
        end else begin
            if (do_digit) begin
                // First digit after EQU starts a fresh chain.
                if (idle_like && after_equ) begin
                    acc        <= '0;
                    pending_op <= OP_ADD;
                    after_equ  <= 1'b0;
                end
                if (digit_room) begin
                    operand   <= operand * WIDTH'(10) + WIDTH'(digit);
                    digit_cnt <= digit_cnt + CW'(1);
                end
            end
            if (do_neg) neg <= ~neg;
            if (do_commit) begin
                pending_op <= (key_op == OP_EQU) ? OP_ADD : key_op;
                after_equ  <= (key_op == OP_EQU);
                operand    <= '0;
                neg        <= 1'b0;
                digit_cnt  <= '0;
            end
            if ((state == S_EXEC) && exec_last) begin
                acc <= exec_res;
                if (exec_ovf) ovf <= 1'b1;
            end
        end
    end

    // NOTE: scratch datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (do_exec) begin
            exec_op <= pending_op;
            rhs     <= entry_val;
            res_neg <= acc[WIDTH-1] ^ entry_val[WIDTH-1];
            cnt     <= '0;
            mul_a   <= {{WIDTH{1'b0}}, mag(acc)};
            mul_b   <= mag(entry_val);
            prod    <= '0;
`ifdef CALC_DIV_EN
            div_dvd <= mag(acc);
            div_dvs <= mag(entry_val);
            div_rem <= '0;
            div_quo <= '0;
`endif
        end else if (state == S_EXEC) begin
            cnt   <= cnt + NW'(1);
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            prod  <= prod_nxt;
`ifdef CALC_DIV_EN
            div_dvd <= div_dvd << 1;
            div_rem <= div_rem_nxt;
            div_quo <= div_quo_nxt;
`endif
        end
    end

endmodule
